// File: rtl/serdes_prbs_pkg.sv
// serdes_prbs_pkg: shared constants and types
// for the PRBS7 (x^7+x^6+1) link-test checker.
package serdes_prbs_pkg;

    localparam int DATA_W     = 32;
    localparam int PRBS_ORDER = 7;
    localparam int PRBS_TAP_A = 7;
    localparam int PRBS_TAP_B = 6;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } prbs_state_t;

    // Per-bit mismatch of a word against the recurrence,
    // using the 7 newest bits of the previous word.
    function automatic logic [DATA_W-1:0] prbs7_mismatch(
        input logic [DATA_W-1:0]     word,
        input logic [PRBS_ORDER-1:0] hist
    );
        logic [DATA_W+PRBS_ORDER-1:0] ext;
        logic [DATA_W-1:0]            mis;
        ext = {word, hist};
        for (int m = 0; m < DATA_W; m++) begin
            mis[m] = word[m]
                   ^ ext[m + PRBS_ORDER - PRBS_TAP_A]
                   ^ ext[m + PRBS_ORDER - PRBS_TAP_B];
        end
        return mis;
    endfunction

endpackage

// File: rtl/prbs7_checker_popcount.sv
// prbs_popcount32: registered population count
// of a 32-bit mismatch vector (pipeline stage 2).
module prbs_popcount32
    import serdes_prbs_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    output logic [5:0]        cnt
);

    logic [5:0] sum;

    // Adder chain over all bits.
    always_comb begin
        sum = '0;
        for (int i = 0; i < DATA_W; i++) begin
            sum = sum + {5'd0, din[i]};
        end
    end

    // Register the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= sum;
        end
    end

endmodule

// File: rtl/prbs7_checker.sv
// prbs7_checker: self-synchronising PRBS7 receive
// checker with lock FSM and saturating BER counters.
module prbs7_checker
    import serdes_prbs_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int LOCK_WORDS   = 8,
    parameter int UNLOCK_WORDS = 4,
    parameter int BAD_THRESH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              cnt_clr,
    output logic              locked,
    output logic [DATA_W-1:0] err_mask,
    output logic              err_mask_valid,
    output logic [CNT_W-1:0]  bit_err_cnt,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int RUN_MAX =
        (LOCK_WORDS > UNLOCK_WORDS) ? LOCK_WORDS : UNLOCK_WORDS;
    localparam int RUN_W = $clog2(RUN_MAX) + 1;
    localparam int SUM_W = ((CNT_W > 6) ? CNT_W : 6) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX =
        (SUM_W'(1) << CNT_W) - SUM_W'(1);

    logic [DATA_W-1:0]     d0;
    logic                  v0;

    logic [PRBS_ORDER-1:0] hist;
    logic                  primer;
    logic [DATA_W-1:0]     m1;
    logic                  v1;
    logic                  z1;

    logic [5:0]            pop2;
    logic [DATA_W-1:0]     m2;
    logic                  v2;
    logic                  z2;

    prbs_state_t           state;
    prbs_state_t           state_n;
    logic [RUN_W-1:0]      run;
    logic [RUN_W-1:0]      run_n;
    logic [RUN_W-1:0]      run_inc;
    logic                  rearm;
    logic                  good_w;
    logic                  bad_w;
    logic                  cnt_en;
    logic [SUM_W-1:0]      bit_sum;

    // Stage 0: capture the incoming word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0 <= '0;
            v0 <= 1'b0;
        end else begin
            v0 <= data_valid;
            if (data_valid) begin
                d0 <= data_in;
            end
        end
    end

    // Stage 1: history, primer handling, mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist   <= '0;
            primer <= 1'b1;
            m1     <= '0;
            v1     <= 1'b0;
            z1     <= 1'b0;
        end else begin
            v1 <= 1'b0;
            if (v0) begin
                hist <= d0[DATA_W-1 -: PRBS_ORDER];
                if (primer) begin
                    primer <= 1'b0;
                end else begin
                    v1 <= 1'b1;
                    m1 <= prbs7_mismatch(d0, hist);
                    z1 <= (d0 == '0);
                end
            end
            if (rearm) begin
                primer <= 1'b1;
            end
        end
    end

    prbs_popcount32 u_pop (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (m1),
        .cnt   (pop2)
    );

    // Stage 2: present the mask alongside its popcount.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m2 <= '0;
            v2 <= 1'b0;
            z2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                m2 <= m1;
                z2 <= z1;
            end
        end
    end

    assign err_mask       = m2;
    assign err_mask_valid = v2;

    assign good_w  = v2 && (pop2 == 6'd0) && !z2;
    assign bad_w   = v2 && (z2 ||
                     ({26'd0, pop2} >= 32'(BAD_THRESH)));
    assign run_inc = run + RUN_W'(1);

    // Lock FSM next-state: run counting in both states.
    always_comb begin
        state_n = state;
        run_n   = run;
        rearm   = 1'b0;
        if (v2) begin
            unique case (state)
                HUNT: begin
                    if (!good_w) begin
                        run_n = '0;
                    end else if (run_inc == RUN_W'(LOCK_WORDS)) begin
                        state_n = LOCKED;
                        run_n   = '0;
                    end else begin
                        run_n = run_inc;
                    end
                end
                LOCKED: begin
                    if (!bad_w) begin
                        run_n = '0;
                    end else if (run_inc == RUN_W'(UNLOCK_WORDS)) begin
                        state_n = HUNT;
                        run_n   = '0;
                        rearm   = 1'b1;
                    end else begin
                        run_n = run_inc;
                    end
                end
            endcase
        end
    end

    // Stage 3: FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            run   <= '0;
        end else begin
            state <= state_n;
            run   <= run_n;
        end
    end

    assign locked  = (state == LOCKED);
    assign cnt_en  = v2 && (state == LOCKED);
    assign bit_sum = SUM_W'(bit_err_cnt) + SUM_W'(pop2);

    // Stage 3: saturating BER counters; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_err_cnt <= '0;
            word_cnt    <= '0;
        end else if (cnt_clr) begin
            bit_err_cnt <= '0;
            word_cnt    <= '0;
        end else if (cnt_en) begin
            if (word_cnt != '1) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if (bit_sum > CNT_MAX) begin
                bit_err_cnt <= '1;
            end else begin
                bit_err_cnt <= bit_sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_prbs7_checker.sv
// tb_prbs7_checker: randomized and directed bench
// with a transaction-level reference model.
module tb_prbs7_checker;

    localparam int LOCKW   = 8;
    localparam int UNLOCKW = 4;
    localparam int BADT    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        locked;
    logic [31:0] err_mask;
    logic        err_mask_valid;
    logic [31:0] bit_err_cnt;
    logic [31:0] word_cnt;

    logic        locked4;
    logic [31:0] err_mask4;
    logic        emv4;
    logic [3:0]  bit4;
    logic [3:0]  word4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state
    bit          m_locked;
    int          m_run;
    bit          m_primer;
    logic [31:0] m_prev;
    bit          ev_mv [8];
    logic [31:0] ev_mask [8];
    bit          ev_lv [8];
    bit          ev_lock [8];
    bit          ev_cv [8];
    int          ev_pop [8];

    bit          exp_locked;
    bit          exp_mv;
    logic [31:0] exp_mask;
    longint      exp_bit, exp_word, exp_bit4, exp_word4;

    logic [6:0]  g = 7'h7F;

    always #5 clk = ~clk;

    prbs7_checker u_dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .data_valid(data_valid), .cnt_clr(cnt_clr),
        .locked(locked), .err_mask(err_mask),
        .err_mask_valid(err_mask_valid),
        .bit_err_cnt(bit_err_cnt), .word_cnt(word_cnt)
    );

    prbs7_checker #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .data_valid(data_valid), .cnt_clr(cnt_clr),
        .locked(locked4), .err_mask(err_mask4),
        .err_mask_valid(emv4),
        .bit_err_cnt(bit4), .word_cnt(word4)
    );

    // next 32 bits of the ideal sequence, bit 0 first
    task automatic next_word(output logic [31:0] w);
        logic b;
        for (int i = 0; i < 32; i++) begin
            b = g[0] ^ g[1];
            w[i] = b;
            g = {b, g[6:1]};
        end
    endtask

    function automatic bit sbit(input logic [31:0] d, input int k);
        if (k >= 0) return d[k];
        return m_prev[32 + k];
    endfunction

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_run = 0; m_primer = 1; m_prev = '0;
        for (int i = 0; i < 8; i++) begin
            ev_mv[i] = 0; ev_lv[i] = 0; ev_cv[i] = 0;
        end
        exp_locked = 0; exp_mv = 0; exp_mask = '0;
        exp_bit = 0; exp_word = 0; exp_bit4 = 0; exp_word4 = 0;
    endtask

    task automatic model_word(input logic [31:0] d);
        logic [31:0] mk;
        int pop, i2, i3;
        bit zero;
        if (m_primer) begin
            m_primer = 0;
            m_prev = d;
            return;
        end
        for (int m = 0; m < 32; m++)
            mk[m] = d[m] ^ sbit(d, m - 7) ^ sbit(d, m - 6);
        m_prev = d;
        pop = $countones(mk);
        zero = (d == 32'd0);
        i2 = (cyc + 2) % 8;
        i3 = (cyc + 3) % 8;
        ev_mv[i2] = 1; ev_mask[i2] = mk;
        if (m_locked) begin
            ev_cv[i3] = 1; ev_pop[i3] = pop;
            m_run = (zero || pop >= BADT) ? m_run + 1 : 0;
            if (m_run == UNLOCKW) begin
                m_locked = 0; m_run = 0; m_primer = 1;
            end
        end else begin
            m_run = (pop == 0 && !zero) ? m_run + 1 : 0;
            if (m_run == LOCKW) begin
                m_locked = 1; m_run = 0;
            end
        end
        ev_lv[i3] = 1; ev_lock[i3] = m_locked;
    endtask

    // drive one cycle, advance the model, sample 1ns after the edge
    task automatic step(input bit v, input logic [31:0] d, input bit clr);
        int ix;
        @(negedge clk);
        data_valid = v; data_in = d; cnt_clr = clr;
        @(posedge clk);
        cyc++;
        if (v) model_word(d);
        ix = cyc % 8;
        exp_mv = ev_mv[ix];
        if (ev_mv[ix]) exp_mask = ev_mask[ix];
        if (ev_lv[ix]) exp_locked = ev_lock[ix];
        if (ev_cv[ix]) begin
            exp_word  = sat(exp_word + 1, 64'hFFFF_FFFF);
            exp_bit   = sat(exp_bit + ev_pop[ix], 64'hFFFF_FFFF);
            exp_word4 = sat(exp_word4 + 1, 15);
            exp_bit4  = sat(exp_bit4 + ev_pop[ix], 15);
        end
        ev_mv[ix] = 0; ev_lv[ix] = 0; ev_cv[ix] = 0;
        if (clr) begin
            exp_bit = 0; exp_word = 0; exp_bit4 = 0; exp_word4 = 0;
        end
        #1;
    endtask

    task automatic apply_reset();
        data_valid = 0; cnt_clr = 0; rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({locked, err_mask_valid, err_mask, bit_err_cnt, word_cnt} !== '0) begin
            errors++;
            $display("FAIL reset outputs got=%0b/%0b/%h/%0d/%0d exp=0",
                     locked, err_mask_valid, err_mask, bit_err_cnt, word_cnt);
        end
        checks++;
        if ({locked4, emv4, bit4, word4} !== '0) begin
            errors++;
            $display("FAIL reset4 outputs got=%0b/%0b/%0d/%0d exp=0",
                     locked4, emv4, bit4, word4);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_clean();
        logic [31:0] w;
        int p0, rise;
        bit pl;
        p0 = cyc + 1; rise = -1; pl = 0;
        for (int i = 0; i < 304; i++) begin
            if (i < 300) next_word(w);
            step(i < 300, w, 0);
            if (locked && !pl && rise < 0) rise = cyc;
            pl = locked;
            checks += 5;
            if (locked !== exp_locked) begin errors++;
                $display("FAIL clean.locked @%0d got=%0b exp=%0b", cyc, locked, exp_locked); end
            if (err_mask_valid !== exp_mv) begin errors++;
                $display("FAIL clean.emv @%0d got=%0b exp=%0b", cyc, err_mask_valid, exp_mv); end
            if (bit_err_cnt !== exp_bit[31:0]) begin errors++;
                $display("FAIL clean.bits @%0d got=%0d exp=%0d", cyc, bit_err_cnt, exp_bit); end
            if (word_cnt !== exp_word[31:0]) begin errors++;
                $display("FAIL clean.words @%0d got=%0d exp=%0d", cyc, word_cnt, exp_word); end
            if (word4 !== exp_word4[3:0]) begin errors++;
                $display("FAIL clean.words4 @%0d got=%0d exp=%0d", cyc, word4, exp_word4); end
        end
        checks += 3;
        if (rise - p0 != 11) begin errors++;
            $display("FAIL clean.lock_time got=%0d exp=11", rise - p0); end
        if (bit_err_cnt !== 32'd0) begin errors++;
            $display("FAIL clean.no_errors got=%0d exp=0", bit_err_cnt); end
        if (word_cnt !== 32'(300 - LOCKW - 1)) begin errors++;
            $display("FAIL clean.word_total got=%0d exp=%0d", word_cnt, 300 - LOCKW - 1); end
    endtask

    task automatic test_single_error();
        logic [31:0] w;
        longint b0;
        b0 = exp_bit;
        for (int i = 0; i < 5; i++) begin
            next_word(w);
            step(1, (i == 0) ? (w ^ 32'h0000_1000) : w, 0);
            if (i == 2) begin
                checks++;
                if (err_mask_valid !== 1'b1 || err_mask !== 32'h000C_1000) begin errors++;
                    $display("FAIL single.mask got=%0b/%h exp=1/000c1000", err_mask_valid, err_mask); end
            end
            if (i == 3) begin
                checks++;
                if (bit_err_cnt !== 32'(b0 + 3)) begin errors++;
                    $display("FAIL single.count got=%0d exp=%0d", bit_err_cnt, b0 + 3); end
            end
        end
    endtask

    task automatic test_boundary_error();
        logic [31:0] w;
        longint b0;
        b0 = exp_bit;
        for (int i = 0; i < 6; i++) begin
            next_word(w);
            step(1, (i == 0) ? (w ^ 32'h4000_0000) : w, 0);
            if (i == 2) begin
                checks++;
                if (err_mask !== 32'h4000_0000) begin errors++;
                    $display("FAIL boundary.mask0 got=%h exp=40000000", err_mask); end
            end
            if (i == 3) begin
                checks++;
                if (err_mask !== 32'h0000_0030) begin errors++;
                    $display("FAIL boundary.mask1 got=%h exp=00000030", err_mask); end
            end
            if (i == 4) begin
                checks++;
                if (bit_err_cnt !== 32'(b0 + 3)) begin errors++;
                    $display("FAIL boundary.count got=%0d exp=%0d", bit_err_cnt, b0 + 3); end
            end
        end
    endtask

    task automatic test_loss_of_lock();
        logic [31:0] w;
        int e4, p;
        for (int i = 0; i < 4; i++) step(1, 32'd0, 0);
        e4 = cyc;
        for (int i = 0; i < 5; i++) begin
            step(0, 32'd0, 0);
            if (cyc == e4 + 2 || cyc == e4 + 3) begin
                checks++;
                if (locked !== (cyc == e4 + 2)) begin errors++;
                    $display("FAIL lol.fall @%0d got=%0b exp=%0b", cyc - e4, locked, cyc == e4 + 2); end
            end
        end
        p = cyc + 1;
        for (int i = 0; i < 14; i++) begin
            next_word(w);
            step(1, w, 0);
            checks++;
            if (locked !== exp_locked) begin errors++;
                $display("FAIL lol.relock @%0d got=%0b exp=%0b", cyc, locked, exp_locked); end
            if (cyc == p + 10 || cyc == p + 11) begin
                checks++;
                if (locked !== (cyc == p + 11)) begin errors++;
                    $display("FAIL lol.relock_time @%0d got=%0b exp=%0b", cyc - p, locked, cyc == p + 11); end
            end
        end
    endtask

    task automatic test_valid_gaps();
        logic [31:0] w;
        int nv, e9, rise;
        bit pl;
        apply_reset();
        nv = 0; e9 = -1; rise = -1; pl = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin next_word(w); nv++; end
            step(i % 2 == 0, w, 0);
            if (nv == 9 && e9 < 0) e9 = cyc;
            if (locked && !pl && rise < 0) rise = cyc;
            pl = locked;
            checks += 2;
            if (locked !== exp_locked) begin errors++;
                $display("FAIL gaps.locked @%0d got=%0b exp=%0b", cyc, locked, exp_locked); end
            if (err_mask_valid !== exp_mv) begin errors++;
                $display("FAIL gaps.emv @%0d got=%0b exp=%0b", cyc, err_mask_valid, exp_mv); end
        end
        checks += 3;
        if (rise != e9 + 3) begin errors++;
            $display("FAIL gaps.lock_time got=%0d exp=%0d", rise, e9 + 3); end
        if (bit_err_cnt !== 32'd0) begin errors++;
            $display("FAIL gaps.no_errors got=%0d exp=0", bit_err_cnt); end
        if (word_cnt !== exp_word[31:0]) begin errors++;
            $display("FAIL gaps.words got=%0d exp=%0d", word_cnt, exp_word); end
    endtask

    task automatic test_clear();
        logic [31:0] w;
        for (int i = 0; i < 5; i++) begin
            next_word(w);
            step(1, (i == 0) ? (w ^ 32'h0000_1000) : w, i == 3);
            if (i == 3) begin
                checks++;
                if ({bit_err_cnt, word_cnt, bit4, word4} !== '0) begin errors++;
                    $display("FAIL clear.zero got=%0d/%0d/%0d/%0d exp=0",
                             bit_err_cnt, word_cnt, bit4, word4); end
            end
            if (i == 4) begin
                checks += 2;
                if (locked !== 1'b1) begin errors++;
                    $display("FAIL clear.fsm got=%0b exp=1", locked); end
                if (word_cnt !== exp_word[31:0]) begin errors++;
                    $display("FAIL clear.resume got=%0d exp=%0d", word_cnt, exp_word); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] w;
        int p;
        for (int i = 0; i < 3; i++) begin next_word(w); step(1, w, 0); end
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if ({locked, err_mask_valid, err_mask, bit_err_cnt, word_cnt, bit4, word4} !== '0) begin
            errors++;
            $display("FAIL midreset.async got=%0b/%0b/%h/%0d/%0d exp=0",
                     locked, err_mask_valid, err_mask, bit_err_cnt, word_cnt);
        end
        apply_reset();
        p = cyc + 1;
        for (int i = 0; i < 14; i++) begin
            next_word(w);
            step(1, w, 0);
            checks++;
            if (locked !== exp_locked) begin errors++;
                $display("FAIL midreset.locked @%0d got=%0b exp=%0b", cyc, locked, exp_locked); end
            if (cyc == p + 2) begin
                checks++;
                if (err_mask_valid !== 1'b0) begin errors++;
                    $display("FAIL midreset.primer got=%0b exp=0", err_mask_valid); end
            end
            if (cyc == p + 11) begin
                checks++;
                if (locked !== 1'b1) begin errors++;
                    $display("FAIL midreset.relock got=%0b exp=1", locked); end
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] w;
        next_word(w);
        step(1, w, 1);
        for (int i = 0; i < 14; i++) begin
            next_word(w);
            step(1, (i < 10) ? (w ^ 32'h0000_1000) : w, 0);
            checks += 2;
            if (bit4 !== exp_bit4[3:0]) begin errors++;
                $display("FAIL sat.bits4 @%0d got=%0d exp=%0d", cyc, bit4, exp_bit4); end
            if (bit_err_cnt !== exp_bit[31:0]) begin errors++;
                $display("FAIL sat.bits @%0d got=%0d exp=%0d", cyc, bit_err_cnt, exp_bit); end
        end
        checks += 2;
        if (bit4 !== 4'hF) begin errors++;
            $display("FAIL sat.hold got=%0d exp=15", bit4); end
        if (locked4 !== 1'b1) begin errors++;
            $display("FAIL sat.locked got=%0b exp=1", locked4); end
    endtask

    task automatic test_random();
        logic [31:0] w;
        bit v, clr, last_flip, flip;
        for (int i = 0; i < 500; i++) begin
            v = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 63) == 0);
            flip = 0;
            if (v) begin
                next_word(w);
                flip = !last_flip && ($urandom_range(0, 15) == 0);
                if (flip) w[$urandom_range(0, 31)] ^= 1'b1;
                last_flip = flip;
            end
            step(v, w, clr);
            checks += 6;
            if (locked !== exp_locked) begin errors++;
                $display("FAIL rand.locked @%0d got=%0b exp=%0b", cyc, locked, exp_locked); end
            if (err_mask_valid !== exp_mv) begin errors++;
                $display("FAIL rand.emv @%0d got=%0b exp=%0b", cyc, err_mask_valid, exp_mv); end
            if (err_mask !== exp_mask) begin errors++;
                $display("FAIL rand.mask @%0d got=%h exp=%h", cyc, err_mask, exp_mask); end
            if (bit_err_cnt !== exp_bit[31:0]) begin errors++;
                $display("FAIL rand.bits @%0d got=%0d exp=%0d", cyc, bit_err_cnt, exp_bit); end
            if (word_cnt !== exp_word[31:0]) begin errors++;
                $display("FAIL rand.words @%0d got=%0d exp=%0d", cyc, word_cnt, exp_word); end
            if (bit4 !== exp_bit4[3:0] || word4 !== exp_word4[3:0]) begin errors++;
                $display("FAIL rand.cnt4 @%0d got=%0d/%0d exp=%0d/%0d",
                         cyc, bit4, word4, exp_bit4, exp_word4); end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_error();
        test_boundary_error();
        test_loss_of_lock();
        test_valid_gaps();
        test_clear();
        test_reset_midstream();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
